mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: turns EX/MEM loads/stores into a req/ack bus transaction, stalls the pipe
// meanwhile and registers the MEM/WB outputs. Optional misalignment trap: MISALIGN_TRAP_EN.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  WB_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_data_i,
    input  logic [4:0]  mux3_result_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic [1:0]  WB_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  RDaddr_o,
    output logic        bus_err_o,
    output logic        misalign_o
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        is_read_q, is_read_d;
    logic [1:0]  cap_wb_q, cap_wb_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic [31:0] cap_alu_q, cap_alu_d;
    logic [31:0] cap_rdata_q, cap_rdata_d;
    logic        err_q, err_d;
    logic [1:0]  wb_q, wb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] alu_q, alu_d;
    logic [4:0]  rd_q, rd_d;
    logic        stall;
    logic        access;
    logic        trap;

    assign access = MemRead_i | MemWrite_i;

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign trap       = access && (Address_i[1:0] != 2'b00);
    assign misalign_d = (state_q == IDLE) && trap;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign misalign_o = misalign_q;
`else
    assign trap       = 1'b0;
    assign misalign_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_read_d   = is_read_q;
        cap_wb_d    = cap_wb_q;
        cap_rd_d    = cap_rd_q;
        cap_alu_d   = cap_alu_q;
        cap_rdata_d = cap_rdata_q;
        err_d       = 1'b0;
        wb_d        = wb_q;
        rdata_d     = rdata_q;
        alu_d       = alu_q;
        rd_d        = rd_q;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !trap) begin
                    // Latch the whole request now; EX/MEM stays frozen but the bus sees flops.
                    stall       = 1'b1;
                    state_d     = WAIT;
                    cnt_d       = '0;
                    we_d        = MemWrite_i;
                    addr_d      = {Address_i[31:2], 2'b00};
                    wdata_d     = Write_data_i;
                    is_read_d   = ~MemWrite_i;
                    cap_wb_d    = WB_i;
                    cap_rd_d    = mux3_result_i;
                    cap_alu_d   = Address_i;
                    cap_rdata_d = '0;
                    wb_d        = 2'b00;
                end else begin
                    wb_d    = trap ? 2'b00 : WB_i;
                    alu_d   = Address_i;
                    rd_d    = mux3_result_i;
                    rdata_d = '0;
                end
            end
            WAIT: begin
                stall = 1'b1;
                wb_d  = 2'b00;
                if (mem_ack_i) begin
                    cap_rdata_d = is_read_q ? mem_rdata_i : '0;
                    state_d     = DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                // Pipe is released this cycle, so the held instruction retires exactly once.
                state_d = IDLE;
                wb_d    = err_q ? 2'b00 : cap_wb_q;
                rdata_d = err_q ? '0 : cap_rdata_q;
                alu_d   = cap_alu_q;
                rd_d    = cap_rd_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_read_q   <= 1'b0;
            cap_wb_q    <= '0;
            cap_rd_q    <= '0;
            cap_alu_q   <= '0;
            cap_rdata_q <= '0;
            err_q       <= 1'b0;
            wb_q        <= '0;
            rdata_q     <= '0;
            alu_q       <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_read_q   <= is_read_d;
            cap_wb_q    <= cap_wb_d;
            cap_rd_q    <= cap_rd_d;
            cap_alu_q   <= cap_alu_d;
            cap_rdata_q <= cap_rdata_d;
            err_q       <= err_d;
            wb_q        <= wb_d;
            rdata_q     <= rdata_d;
            alu_q       <= alu_d;
            rd_q        <= rd_d;
        end
    end

    // Stall is combinational from the inputs, so gate it with reset to keep outputs at 0.
    assign stall_o     = stall & rst_i;
    assign mem_req_o   = (state_q == WAIT);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign bus_err_o   = err_q;
    assign WB_o        = wb_q;
    assign ReadData_o  = rdata_q;
    assign ALUResult_o = alu_q;
    assign RDaddr_o    = rd_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized scoreboard bench for mem_access_stage: driver models EX/MEM, a responder models
// the data memory, a monitor checks each retired instruction against a queue of expectations.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  WB_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] Address_i, Write_data_i;
    logic [4:0]  mux3_result_i;
    logic        mem_req_o, mem_we_o, mem_ack_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        stall_o;
    logic [1:0]  WB_o;
    logic [31:0] ReadData_o, ALUResult_o;
    logic [4:0]  RDaddr_o;
    logic        bus_err_o, misalign_o;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .WB_i(WB_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .Address_i(Address_i), .Write_data_i(Write_data_i), .mux3_result_i(mux3_result_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .WB_o(WB_o), .ReadData_o(ReadData_o), .ALUResult_o(ALUResult_o),
        .RDaddr_o(RDaddr_o), .bus_err_o(bus_err_o), .misalign_o(misalign_o)
    );

    typedef struct {
        logic [1:0]  wb;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        int          stalls;
        logic        err;
        logic        mis;
    } exp_t;

    typedef struct {
        int          delay;   // WAIT cycle carrying the ack; 0 = never ack
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        abort;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem[64];
    logic [31:0] resp_mem[64];
    logic        inst_valid = 1'b0;
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hCAFE_0001 : (32'h5A00_0000 ^ (32'(i) * 32'h0001_0013));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: one instruction's architectural effect, then wait until EX/MEM advances.
    task automatic issue(input logic [1:0] wb, input logic rd_en, input logic wr_en,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rdst, input int delay_in);
        exp_t e;
        req_t r;
        int   d;
        int   idx;
        logic acc, mis;
        bit   ok;
        acc = rd_en | wr_en;
`ifdef MISALIGN_TRAP_EN
        mis = acc && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        idx = int'(addr[7:2]);
        e.alu = addr; e.rd = rdst; e.mis = mis; e.err = 1'b0;
        e.rdata = '0; e.wb = mis ? 2'b00 : wb; e.stalls = 0;
        if (acc && !mis) begin
            if (delay_in >= 0) d = delay_in;
            else d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            r.delay = d; r.we = wr_en; r.addr = {addr[31:2], 2'b00};
            r.wdata = wdata; r.abort = 1'b0;
            req_q.push_back(r);
            e.stalls = 1 + ((d == 0) ? TO : d);
            if (d == 0) begin
                e.err = 1'b1;
                e.wb  = 2'b00;
            end else if (wr_en) begin
                ref_mem[idx] = wdata;
            end else begin
                e.rdata = ref_mem[idx];
            end
        end
        exp_q.push_back(e);
        WB_i = wb; MemRead_i = rd_en; MemWrite_i = wr_en;
        Address_i = addr; Write_data_i = wdata; mux3_result_i = rdst;
        inst_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3 * TO + 10; i++) begin
            @(negedge clk);
            if (!stall_o) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL accept_timeout: stall_o still 1, expected release within %0d cycles", 3 * TO + 10);
        end
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
    endtask

    // Memory responder: checks the request is stable each WAIT cycle and acks on schedule.
    initial begin
        req_t cur;
        bit   busy;
        int   k;
        int   idx;
        for (int i = 0; i < 64; i++) resp_mem[i] = init_word(i);
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        busy = 1'b0;
        k = 0;
        cur = '{delay: 0, we: 1'b0, addr: 32'h0, wdata: 32'h0, abort: 1'b0};
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                if (!busy) begin
                    if (req_q.size() == 0) begin
                        chk("unexpected_req", 32'h1, 32'h0);
                        cur = '{delay: 0, we: 1'b0, addr: mem_addr_o, wdata: 32'h0, abort: 1'b1};
                    end else begin
                        cur = req_q.pop_front();
                    end
                    busy = 1'b1;
                    k = 0;
                end
                k++;
                chk("mem_addr", mem_addr_o, cur.addr);
                chk("mem_we", {31'b0, mem_we_o}, {31'b0, cur.we});
                if (cur.we) chk("mem_wdata", mem_wdata_o, cur.wdata);
                idx = int'(mem_addr_o[7:2]);
                if (cur.delay == k) begin
                    mem_ack_i = 1'b1;
                    mem_rdata_i = cur.we ? $urandom() : resp_mem[idx];
                    if (cur.we) resp_mem[idx] = mem_wdata_o;
                end else begin
                    mem_ack_i = 1'b0;
                    mem_rdata_i = $urandom();
                end
            end else begin
                if (busy && !cur.abort && cur.delay == 0) chk("req_cycles_timeout", k, TO);
                busy = 1'b0;
                mem_ack_i = ($urandom_range(0, 3) == 0);
                mem_rdata_i = $urandom();
            end
        end
    end

    // Monitor: an instruction retires on each edge where stall_o was low while it was presented.
    initial begin
        int run;
        run = 0;
        forever begin
            logic s, v, r, be;
            exp_t e;
            @(negedge clk);
            s = stall_o; v = inst_valid; r = rst_i; be = bus_err_o;
            @(posedge clk);
            #1;
            if (!r || !rst_i) begin
                run = 0;
            end else if (s) begin
                run++;
                chk("bubble_wb", {30'b0, WB_o}, 32'h0);
                chk("bus_err_quiet", {31'b0, be}, 32'h0);
            end else if (v) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", 32'h1, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_o", {30'b0, WB_o}, {30'b0, e.wb});
                    chk("read_data", ReadData_o, e.rdata);
                    chk("alu_result", ALUResult_o, e.alu);
                    chk("rd_addr", {27'b0, RDaddr_o}, {27'b0, e.rd});
                    chk("stall_cycles", run, e.stalls);
                    chk("bus_err", {31'b0, be}, {31'b0, e.err});
                    chk("misalign", {31'b0, misalign_o}, {31'b0, e.mis});
                end
                run = 0;
            end else begin
                run = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t ra;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        rst_i = 1'b0;
        WB_i = 2'b11; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        Address_i = 32'h0000_0010; Write_data_i = 32'h0; mux3_result_i = 5'd1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_wb", {30'b0, WB_o}, 32'h0);
        chk("rst_alu", ALUResult_o, 32'h0);
        chk("rst_rdata", ReadData_o, 32'h0);
        chk("rst_rd", {27'b0, RDaddr_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_bus_err", {31'b0, bus_err_o}, 32'h0);
        MemRead_i = 1'b0;
        #1 rst_i = 1'b1;
        @(posedge clk);
        #1;

        issue(2'b10, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd7, 3);
        issue(2'b01, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678, 5'd3, 1);
        issue(2'b11, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 5'd9, 2);
        issue(2'b11, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd4, 0);
        issue(2'b10, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 5'd5, TO);
        issue(2'b11, 1'b1, 1'b1, 32'h0000_0044, 32'hA1B2_C3D4, 5'd6, 1);
        issue(2'b10, 1'b1, 1'b0, 32'h0000_0013, 32'h0, 5'd8, 1);
        for (int i = 0; i < 8; i++)
            issue(2'($urandom_range(0, 3)), 1'b0, 1'b0, $urandom(), $urandom(), 5'($urandom_range(0, 31)), -1);

        // Reset pulled in the second WAIT cycle, then the same read retried.
        WB_i = 2'b01; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        Address_i = 32'h0000_0020; Write_data_i = 32'h0; mux3_result_i = 5'd11;
        ra = '{delay: 0, we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, abort: 1'b1};
        req_q.push_back(ra);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("pre_rst_req", {31'b0, mem_req_o}, 32'h1);
        rst_i = 1'b0;
        #1;
        chk("async_rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("async_rst_stall", {31'b0, stall_o}, 32'h0);
        chk("async_rst_mem_addr", mem_addr_o, 32'h0);
        chk("async_rst_alu", ALUResult_o, 32'h0);
        @(posedge clk);
        #1;
        chk("held_rst_req", {31'b0, mem_req_o}, 32'h0);
        rst_i = 1'b1;
        issue(2'b01, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 5'd11, 2);

        for (int i = 0; i < 150; i++) begin
            int   t;
            logic rd_en, wr_en;
            t = int'($urandom_range(0, 19));
            rd_en = (t >= 8 && t < 14) || (t == 19);
            wr_en = (t >= 14);
            issue(2'($urandom_range(0, 3)), rd_en, wr_en, $urandom(), $urandom(),
                  5'($urandom_range(0, 31)), -1);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("exp_queue_drained", exp_q.size(), 32'h0);
        chk("req_queue_drained", req_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
